// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX/MEM hazard fields in, stage enables,
// clears, forwarding selects and status out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       ex_a3;
    logic             ex_regwrite;
    logic             ex_memtoreg;
    logic [4:0]       mem_a3;
    logic             mem_regwrite;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             regD_en;
    logic             regE_en;
    logic             regM_en;
    logic             regW_en;
    logic             regD_clr;
    logic             regE_clr;
    logic [1:0]       falu_a;
    logic [1:0]       falu_b;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
               ex_a3, ex_regwrite, ex_memtoreg,
               mem_a3, mem_regwrite,
               ex_redirect, mem_req, mem_ready,
        input  pc_en, regD_en, regE_en, regM_en, regW_en,
               regD_clr, regE_clr, falu_a, falu_b,
               halted, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
               ex_a3, ex_regwrite, ex_memtoreg,
               mem_a3, mem_regwrite,
               ex_redirect, mem_req, mem_ready,
        output pc_en, regD_en, regE_en, regM_en, regW_en,
               regD_clr, regE_clr, falu_a, falu_b,
               halted, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard scheduler: forwarding selects, load-use bubbles,
// redirect flushes, data-memory wait freeze with watchdog, stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int unsigned WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_MAX - 1);

    state_t           state_q;
    logic [WC_W-1:0]  wait_ctr_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             halted_q;

    logic             lu;
    logic             freeze;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] ex_a3,
        input logic       ex_regwrite,
        input logic       ex_memtoreg,
        input logic [4:0] mem_a3,
        input logic       mem_regwrite
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != 5'd0) begin
            if (ex_regwrite && !ex_memtoreg && (src == ex_a3)) begin
                sel = 2'b01;
            end else if (mem_regwrite && (src == mem_a3)) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(hz.id_rs, hz.ex_a3, hz.ex_regwrite, hz.ex_memtoreg,
                        hz.mem_a3, hz.mem_regwrite);
        fwd_b = fwd_sel(hz.id_rt, hz.ex_a3, hz.ex_regwrite, hz.ex_memtoreg,
                        hz.mem_a3, hz.mem_regwrite);
    end

    always_comb begin
        lu = hz.ex_memtoreg && hz.ex_regwrite && (hz.ex_a3 != 5'd0) &&
             ((hz.id_use_rs && (hz.id_rs == hz.ex_a3)) ||
              (hz.id_use_rt && (hz.id_rt == hz.ex_a3)));
    end

    always_comb begin
        freeze = 1'b0;
        unique case (state_q)
            ST_RUN:  freeze = hz.mem_req && !hz.mem_ready;
            ST_WAIT: freeze = !hz.mem_ready;
            ST_HALT: freeze = 1'b1;
            default: freeze = 1'b1;
        endcase
    end

    // Redirect outranks load-use: the dependent instruction is squashed anyway.
    always_comb begin
        hz.pc_en    = 1'b1;
        hz.regD_en  = 1'b1;
        hz.regE_en  = 1'b1;
        hz.regM_en  = 1'b1;
        hz.regW_en  = 1'b1;
        hz.regD_clr = 1'b0;
        hz.regE_clr = 1'b0;
        hz.falu_a   = fwd_a;
        hz.falu_b   = fwd_b;

        if (freeze) begin
            hz.pc_en   = 1'b0;
            hz.regD_en = 1'b0;
            hz.regE_en = 1'b0;
            hz.regM_en = 1'b0;
            hz.regW_en = 1'b0;
        end else if (hz.ex_redirect) begin
            hz.regD_clr = 1'b1;
            hz.regE_clr = 1'b1;
        end else if (lu) begin
            hz.pc_en    = 1'b0;
            hz.regD_en  = 1'b0;
            hz.regE_clr = 1'b1;
        end

        if (!rst_n) begin
            hz.pc_en    = 1'b0;
            hz.regD_en  = 1'b0;
            hz.regE_en  = 1'b0;
            hz.regM_en  = 1'b0;
            hz.regW_en  = 1'b0;
            hz.regD_clr = 1'b1;
            hz.regE_clr = 1'b1;
            hz.falu_a   = 2'b00;
            hz.falu_b   = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_ctr_q  <= '0;
            stall_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            if (!hz.pc_en && (state_q != ST_HALT) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                ST_RUN: begin
                    wait_ctr_q <= '0;
                    if (hz.mem_req && !hz.mem_ready) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (hz.mem_ready) begin
                        state_q    <= ST_RUN;
                        wait_ctr_q <= '0;
                    end else if (wait_ctr_q == WC_LAST) begin
                        // This is the WAIT_MAX-th consecutive wait cycle.
                        state_q    <= ST_HALT;
                        halted_q   <= 1'b1;
                        wait_ctr_q <= '0;
                    end else begin
                        wait_ctr_q <= wait_ctr_q + WC_W'(1);
                    end
                end
                ST_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_RUN;
                    wait_ctr_q <= '0;
                end
            endcase
        end
    end

    assign hz.halted    = halted_q;
    assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, flush, memory
// wait, watchdog, reset forcing and stall counter saturation.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   failed;

    pipe_hazard_ctrl_if #(.CNT_W(16)) hz ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  hz4 ();

    pipe_hazard_ctrl #(.WAIT_MAX(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    pipe_hazard_ctrl #(.WAIT_MAX(8), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        hz.id_rs = 5'd0;        hz.id_rt = 5'd0;
        hz.id_use_rs = 1'b0;    hz.id_use_rt = 1'b0;
        hz.ex_a3 = 5'd0;        hz.ex_regwrite = 1'b0;  hz.ex_memtoreg = 1'b0;
        hz.mem_a3 = 5'd0;       hz.mem_regwrite = 1'b0;
        hz.ex_redirect = 1'b0;  hz.mem_req = 1'b0;      hz.mem_ready = 1'b0;
    endtask

    task automatic clr_in4();
        hz4.id_rs = 5'd0;       hz4.id_rt = 5'd0;
        hz4.id_use_rs = 1'b0;   hz4.id_use_rt = 1'b0;
        hz4.ex_a3 = 5'd0;       hz4.ex_regwrite = 1'b0; hz4.ex_memtoreg = 1'b0;
        hz4.mem_a3 = 5'd0;      hz4.mem_regwrite = 1'b0;
        hz4.ex_redirect = 1'b0; hz4.mem_req = 1'b0;     hz4.mem_ready = 1'b0;
    endtask

    // Packs enables as {pc,D,E,M,W} and clears as {D,E}.
    function automatic logic [31:0] ens();
        return {27'd0, hz.pc_en, hz.regD_en, hz.regE_en, hz.regM_en, hz.regW_en};
    endfunction

    function automatic logic [31:0] clrs();
        return {30'd0, hz.regD_clr, hz.regE_clr};
    endfunction

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        clr_in();
        clr_in4();

        // Reset with a forwarding match present: outputs must stay forced.
        rst_n = 1'b0;
        hz.id_rs = 5'd5; hz.ex_a3 = 5'd5; hz.ex_regwrite = 1'b1;
        tick();
        tick();
        chk("rst_ens",    ens(), 32'h00);
        chk("rst_clrs",   clrs(), 32'h3);
        chk("rst_falu_a", 32'(hz.falu_a), 32'h0);
        chk("rst_stall",  32'(hz.stall_cnt), 32'h0);
        chk("rst_halted", 32'(hz.halted), 32'h0);

        rst_n = 1'b1;
        clr_in();
        settle();
        chk("run_ens",  ens(), 32'h1f);
        chk("run_clrs", clrs(), 32'h0);

        // Forwarding
        hz.ex_a3 = 5'd5; hz.ex_regwrite = 1'b1; hz.id_rs = 5'd5;
        settle();
        chk("fwd_ex_a", 32'(hz.falu_a), 32'h1);
        chk("fwd_ex_b", 32'(hz.falu_b), 32'h0);
        hz.mem_a3 = 5'd5; hz.mem_regwrite = 1'b1;
        settle();
        chk("fwd_ex_wins", 32'(hz.falu_a), 32'h1);
        hz.ex_regwrite = 1'b0; hz.id_rt = 5'd5;
        settle();
        chk("fwd_mem_a", 32'(hz.falu_a), 32'h2);
        chk("fwd_mem_b", 32'(hz.falu_b), 32'h2);
        clr_in();
        hz.ex_regwrite = 1'b1; hz.mem_regwrite = 1'b1;
        settle();
        chk("fwd_r0_a", 32'(hz.falu_a), 32'h0);
        chk("fwd_r0_b", 32'(hz.falu_b), 32'h0);
        clr_in();
        hz.ex_a3 = 5'd7; hz.ex_regwrite = 1'b1; hz.ex_memtoreg = 1'b1; hz.id_rs = 5'd7;
        settle();
        chk("fwd_load_no_ex", 32'(hz.falu_a), 32'h0);
        chk("load_unused_no_stall", ens(), 32'h1f);

        // Load-use: lw $3 in EX, add reads $3 in ID
        clr_in();
        hz.ex_a3 = 5'd3; hz.ex_regwrite = 1'b1; hz.ex_memtoreg = 1'b1;
        hz.id_rs = 5'd3; hz.id_use_rs = 1'b1; hz.id_rt = 5'd1; hz.id_use_rt = 1'b1;
        settle();
        chk("lu_ens",  ens(), 32'h07);
        chk("lu_clrs", clrs(), 32'h1);
        tick();
        hz.ex_a3 = 5'd0; hz.ex_regwrite = 1'b0; hz.ex_memtoreg = 1'b0;
        hz.mem_a3 = 5'd3; hz.mem_regwrite = 1'b1;
        settle();
        chk("lu_next_falu_a", 32'(hz.falu_a), 32'h2);
        chk("lu_next_stall",  32'(hz.stall_cnt), 32'h1);
        chk("lu_next_ens",    ens(), 32'h1f);

        // Redirect together with load-use
        clr_in();
        hz.ex_a3 = 5'd3; hz.ex_regwrite = 1'b1; hz.ex_memtoreg = 1'b1;
        hz.id_rs = 5'd3; hz.id_use_rs = 1'b1; hz.ex_redirect = 1'b1;
        settle();
        chk("flush_clrs", clrs(), 32'h3);
        chk("flush_ens",  ens(), 32'h1f);
        tick();
        chk("flush_stall", 32'(hz.stall_cnt), 32'h1);

        // Memory wait with a held redirect, from a fresh counter
        clr_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0; hz.ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("wait_frz_ens%0d", i), ens(), 32'h00);
            chk($sformatf("wait_frz_clr%0d", i), clrs(), 32'h0);
            tick();
        end
        hz.mem_ready = 1'b1;
        settle();
        chk("wait_rel_clrs", clrs(), 32'h3);
        chk("wait_rel_ens",  ens(), 32'h1f);
        tick();
        chk("wait_stall", 32'(hz.stall_cnt), 32'h3);
        clr_in();
        settle();
        chk("wait_back_run", ens(), 32'h1f);

        // Watchdog
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("wd_not_yet", 32'(hz.halted), 32'h0);
        for (int i = 0; i < 4; i++) tick();
        chk("wd_halted", 32'(hz.halted), 32'h1);
        chk("wd_ens",    ens(), 32'h00);
        hz.mem_ready = 1'b1; hz.mem_req = 1'b0;
        tick();
        settle();
        chk("wd_sticky",     32'(hz.halted), 32'h1);
        chk("wd_sticky_ens", ens(), 32'h00);
        rst_n = 1'b0;
        settle();
        chk("wd_rst_force_clrs", clrs(), 32'h3);
        tick();
        chk("wd_rst_halted", 32'(hz.halted), 32'h0);
        chk("wd_rst_stall",  32'(hz.stall_cnt), 32'h0);
        rst_n = 1'b1;
        clr_in();
        settle();
        chk("wd_rst_run", ens(), 32'h1f);

        // Saturation on the 4-bit counter instance via a held load-use
        hz4.ex_a3 = 5'd3; hz4.ex_regwrite = 1'b1; hz4.ex_memtoreg = 1'b1;
        hz4.id_rs = 5'd3; hz4.id_use_rs = 1'b1;
        settle();
        chk("sat_pc_en", 32'(hz4.pc_en), 32'h0);
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", 32'(hz4.stall_cnt), 32'd14);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_20", 32'(hz4.stall_cnt), 32'd15);
        clr_in4();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
